// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: config, ping-pong capture and frame streaming for the FFT core
// Ports:
//   clk_in, rst_in (async, active-high)
//   sample_in/sample_valid_in      audio capture into the ping-pong buffer
//   cfg_t*                          one-shot FFT config word after reset
//   fft_t*                          frame beats {16'h0000 imag, 16b real} with valid/ready/last
//   fft_out_valid_in/fft_out_last_in  FFT output frame completion
//   frame_start_out/frame_done_out  tone-detector frame markers
//   busy_out, drop_count_out, state_out  status
module fft_frame_sequencer #(
    parameter int          SAMPLE_WIDTH = 16,
    parameter int          FRAME_LEN    = 1024,
    parameter logic [15:0] CONFIG_WORD  = 16'h0001
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    output logic [15:0]             cfg_tdata_out,
    output logic                    cfg_tvalid_out,
    input  logic                    cfg_tready_in,
    output logic [31:0]             fft_tdata_out,
    output logic                    fft_tvalid_out,
    output logic                    fft_tlast_out,
    input  logic                    fft_tready_in,
    input  logic                    fft_out_valid_in,
    input  logic                    fft_out_last_in,
    output logic                    frame_start_out,
    output logic                    frame_done_out,
    output logic                    busy_out,
    output logic [15:0]             drop_count_out,
    output logic [1:0]              state_out
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {CFG = 2'd0, IDLE = 2'd1, STREAM = 2'd2, WAIT_OUT = 2'd3} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic           bank_full_q, bank_full_d;
    logic [15:0]    drop_count_q, drop_count_d;
    logic           cfg_valid_q, cfg_valid_d;
    logic           frame_start_q, frame_start_d;
    logic           frame_done_q, frame_done_d;
    logic [15:0]    ram [2*FRAME_LEN];
    logic [15:0]    rd_data_q;
    logic [15:0]    sample_16;
    logic           wr_en, swap;

    assign sample_16 = 16'($signed(sample_in));

    // Capture runs in every state; a swap only happens while the bank is full,
    // so a write and a swap can never coincide.
    always_comb begin
        swap         = (state_q == IDLE) && bank_full_q;
        wr_en        = sample_valid_in && !bank_full_q;
        wr_ptr_d     = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        wr_bank_d    = swap ? ~wr_bank_q : wr_bank_q;
        bank_full_d  = swap ? 1'b0 : (wr_en && wr_ptr_q == LAST) ? 1'b1 : bank_full_q;
        drop_count_d = (sample_valid_in && bank_full_q && drop_count_q != 16'hFFFF)
                       ? drop_count_q + 16'd1 : drop_count_q;
    end

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        rd_bank_d     = rd_bank_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        case (state_q)
            CFG: if (cfg_valid_q && cfg_tready_in) state_d = IDLE;
            IDLE: if (bank_full_q) begin
                state_d       = STREAM;
                rd_bank_d     = wr_bank_q;
                rd_ptr_d      = '0;
                frame_start_d = 1'b1;
            end
            STREAM: if (fft_tready_in) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (rd_ptr_q == LAST) state_d = WAIT_OUT;
            end
            WAIT_OUT: if (fft_out_valid_in && fft_out_last_in) begin
                state_d      = IDLE;
                frame_done_d = 1'b1;
            end
            default: state_d = CFG;
        endcase
        cfg_valid_d = (state_d == CFG);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= CFG;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            bank_full_q   <= 1'b0;
            drop_count_q  <= '0;
            cfg_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            bank_full_q   <= bank_full_d;
            drop_count_q  <= drop_count_d;
            cfg_valid_q   <= cfg_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Read address follows the next pointer, so the registered RAM output already
    // holds the beat presented in the following cycle (no bubbles, stable on stall).
    always_ff @(posedge clk_in) begin
        if (wr_en) ram[{wr_bank_q, wr_ptr_q}] <= sample_16;
        rd_data_q <= ram[{rd_bank_d, rd_ptr_d}];
    end

    assign cfg_tvalid_out  = cfg_valid_q;
    assign cfg_tdata_out   = cfg_valid_q ? CONFIG_WORD : 16'h0000;
    assign fft_tvalid_out  = (state_q == STREAM);
    assign fft_tlast_out   = fft_tvalid_out && (rd_ptr_q == LAST);
    assign fft_tdata_out   = fft_tvalid_out ? {16'h0000, rd_data_q} : 32'h0;
    assign frame_start_out = frame_start_q;
    assign frame_done_out  = frame_done_q;
    assign busy_out        = state_q[1];
    assign drop_count_out  = drop_count_q;
    assign state_out       = state_q;
endmodule
